// File: rtl/sram_ctrl.sv
// Synchronous initiator for an asynchronous SRAM: one request at a time,
// sequenced as setup, a WAIT_CYCLES-long chip-select window, hold, then response.
module sram_ctrl #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [DATA_WIDTH-1:0] mem_data_in,
    input  logic [DATA_WIDTH-1:0] mem_data_out
);

    if (WAIT_CYCLES < 1) begin : g_bad_wait
        $error("sram_ctrl: WAIT_CYCLES must be >= 1");
    end

    localparam int CNT_W = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_HOLD,
        S_RESP
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    cs_q, cs_d;
    logic                    mwe_q, mwe_d;
    logic                    oe_q, oe_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;

    // Every register is loaded with the value it must show in the next state,
    // so the mem_* pins are glitch-free registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cs_d        = cs_q;
        mwe_d       = mwe_q;
        oe_d        = oe_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_we ? req_wdata : '0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                cnt_d   = CNT_LOAD;
                cs_d    = 1'b1;
                mwe_d   = we_q;
                oe_d    = !we_q;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (cnt_q == '0) begin
                    cs_d        = 1'b0;
                    mwe_d       = 1'b0;
                    oe_d        = 1'b0;
                    rsp_rdata_d = we_q ? '0 : mem_data_out;
                    state_d     = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                rsp_valid_d = 1'b1;
                state_d     = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cs_q        <= 1'b0;
            mwe_q       <= 1'b0;
            oe_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cs_q        <= cs_d;
            mwe_q       <= mwe_d;
            oe_q        <= oe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready   = (state_q == S_IDLE) && !rst;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign mem_address = addr_q;
    assign mem_cs      = cs_q;
    assign mem_we      = mwe_q;
    assign mem_oe      = oe_q;
    assign mem_data_in = wdata_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Bench for sram_ctrl: behavioural SRAM models, a reference memory array and
// directed plus random transactions on a WAIT_CYCLES=2 and a WAIT_CYCLES=1 instance.
module tb_sram_ctrl;
    localparam int W = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rst;
    logic       req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [7:0] req_addr, req_wdata, rsp_rdata;
    logic [7:0] mem_address, mem_data_in, mem_data_out;
    logic       mem_cs, mem_we, mem_oe;

    logic       req_valid2, req_ready2, req_we2, rsp_valid2, rsp_ready2;
    logic [7:0] req_addr2, req_wdata2, rsp_rdata2;
    logic [7:0] mem_address2, mem_data_in2, mem_data_out2;
    logic       mem_cs2, mem_we2, mem_oe2;

    sram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_address(mem_address), .mem_cs(mem_cs), .mem_we(mem_we), .mem_oe(mem_oe),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    sram_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .WAIT_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_we(req_we2),
        .req_addr(req_addr2), .req_wdata(req_wdata2),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_rdata(rsp_rdata2),
        .mem_address(mem_address2), .mem_cs(mem_cs2), .mem_we(mem_we2), .mem_oe(mem_oe2),
        .mem_data_in(mem_data_in2), .mem_data_out(mem_data_out2)
    );

    // Asynchronous SRAM models: level-sensitive write, tristated read port.
    logic [7:0] ram  [256];
    logic [7:0] ram2 [256];
    always @(*) if (mem_cs && mem_we) ram[mem_address] = mem_data_in;
    always @(*) if (mem_cs2 && mem_we2) ram2[mem_address2] = mem_data_in2;
    assign mem_data_out  = (mem_cs && mem_oe && !mem_we) ? ram[mem_address] : 8'hzz;
    assign mem_data_out2 = (mem_cs2 && mem_oe2 && !mem_we2) ? ram2[mem_address2] : 8'hzz;

    logic [7:0] ref_mem [256];
    int n_total = 0, n_pass = 0, n_fail = 0;
    int last_acc = 0;

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin n_fail++; $error("FAIL %s: observed %b expected %b", tag, obs, exp); end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin n_fail++; $error("FAIL %s: observed %h expected %h", tag, obs, exp); end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin n_fail++; $error("FAIL %s: observed %0d expected %0d", tag, obs, exp); end
    endtask

    // Pin-level rules on the main instance: we only inside cs, address frozen
    // while we is high, cs asserted for exactly W cycles per access.
    task automatic monitor();
        logic prev_cs, prev_we;
        logic [7:0] prev_addr;
        int run;
        prev_cs = 1'b0; prev_we = 1'b0; prev_addr = 8'h00; run = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_we) check1("we_without_cs", mem_cs, 1'b1);
                if (mem_we && prev_we) check8("addr_change_during_we", mem_address, prev_addr);
                if (prev_cs && !mem_cs) checki("cs_width", run, W);
            end
            run = mem_cs ? run + 1 : 0;
            prev_cs = mem_cs; prev_we = mem_we; prev_addr = mem_address;
        end
    endtask

    // One full transaction with rsp_ready=1, checking every phase against the
    // reference memory and the expected SETUP/ACCESS/HOLD/RESP pin values.
    task automatic xact(input logic we, input logic [7:0] a, input logic [7:0] d, input bit spc);
        int n, acc;
        logic [7:0] exp, din;
        exp = we ? 8'h00 : ref_mem[a];
        din = we ? d : 8'h00;
        if (we) ref_mem[a] = d;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        check1("req_ready_wait", n < 20, 1'b1);
        @(posedge clk); #1;
        acc = cyc;
        if (spc) checki("accept_spacing", acc - last_acc, W + 4);
        last_acc = acc;
        req_valid = 1'b0; req_we = 1'($urandom_range(0, 1));
        req_addr = 8'($urandom); req_wdata = 8'($urandom);
        check1("setup_cs", mem_cs, 1'b0);
        check8("setup_addr", mem_address, a);
        check8("setup_data", mem_data_in, din);
        check1("busy_ready", req_ready, 1'b0);
        for (int k = 0; k < W; k++) begin
            @(posedge clk); #1;
            check1("access_cs", mem_cs, 1'b1);
            check1("access_we", mem_we, we);
            check1("access_oe", mem_oe, !we);
            check8("access_addr", mem_address, a);
            check8("access_data", mem_data_in, din);
            check1("early_rsp", rsp_valid, 1'b0);
        end
        @(posedge clk); #1;
        check1("hold_cs", mem_cs | mem_we | mem_oe, 1'b0);
        check8("hold_addr", mem_address, a);
        check8("hold_data", mem_data_in, din);
        check1("hold_rsp", rsp_valid, 1'b0);
        @(posedge clk); #1;
        check1("rsp_valid", rsp_valid, 1'b1);
        check8("rsp_rdata", rsp_rdata, exp);
        check1("resp_ready", req_ready, 1'b0);
        @(posedge clk); #1;
        check1("rsp_drop", rsp_valid, 1'b0);
        check8("rsp_rdata_kept", rsp_rdata, exp);
        check1("idle_ready", req_ready, 1'b1);
    endtask

    task automatic xact2(input logic we, input logic [7:0] a, input logic [7:0] d, input logic [7:0] exp);
        @(negedge clk);
        check1("w1_ready", req_ready2, 1'b1);
        req_valid2 = 1'b1; req_we2 = we; req_addr2 = a; req_wdata2 = d;
        @(posedge clk); #1;
        req_valid2 = 1'b0;
        @(posedge clk); #1;
        check1("w1_access_cs", mem_cs2, 1'b1);
        check1("w1_early_rsp", rsp_valid2, 1'b0);
        @(posedge clk); #1;
        check1("w1_hold_rsp", rsp_valid2, 1'b0);
        @(posedge clk); #1;
        check1("w1_rsp_valid", rsp_valid2, 1'b1);
        check8("w1_rsp_rdata", rsp_rdata2, exp);
        @(posedge clk); #1;
        check1("w1_rsp_drop", rsp_valid2, 1'b0);
    endtask

    initial begin
        rst = 1'b1; rsp_ready = 1'b1;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h3C; req_wdata = 8'hA5;
        req_valid2 = 1'b0; req_we2 = 1'b0; req_addr2 = 8'h00; req_wdata2 = 8'h00; rsp_ready2 = 1'b1;
        fork
            monitor();
            begin
                #1000000;
                $display("FAIL watchdog: simulation time limit reached");
                $fatal(1);
            end
        join_none

        // Reset held with a pending request: nothing may be issued.
        repeat (3) begin
            @(posedge clk); #1;
            check1("rst_ready", req_ready, 1'b0);
            check1("rst_cs", mem_cs, 1'b0);
            check1("rst_we", mem_we, 1'b0);
            check1("rst_oe", mem_oe, 1'b0);
            check8("rst_addr", mem_address, 8'h00);
            check8("rst_data", mem_data_in, 8'h00);
            check1("rst_rsp_valid", rsp_valid, 1'b0);
            check8("rst_rsp_rdata", rsp_rdata, 8'h00);
        end
        @(negedge clk); rst = 1'b0; req_valid = 1'b0;
        #1 check1("post_rst_ready", req_ready, 1'b1);

        xact(1'b1, 8'h3C, 8'hA5, 1'b0);
        xact(1'b0, 8'h3C, 8'h00, 1'b0);
        xact(1'b1, 8'h10, 8'h5A, 1'b0);

        // Backpressure on a read of 0x10, then a request overlapping the handshake.
        @(negedge clk);
        rsp_ready = 1'b0; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h10; req_wdata = 8'hFF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check1("bp_rsp_valid", rsp_valid, 1'b1);
        check8("bp_rsp_rdata", rsp_rdata, 8'h5A);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check1("bp_valid_held", rsp_valid, 1'b1);
            check8("bp_rdata_held", rsp_rdata, 8'h5A);
            check1("bp_ready_low", req_ready, 1'b0);
        end
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_addr = 8'h3C;
        @(posedge clk); #1;
        check1("hs_rsp_drop", rsp_valid, 1'b0);
        check1("hs_not_accepted", req_ready, 1'b1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        check1("hs_accept_next", req_ready, 1'b0);
        check8("hs_setup_addr", mem_address, 8'h3C);
        repeat (4) @(posedge clk);
        #1;
        check1("hs_rsp_valid", rsp_valid, 1'b1);
        check8("hs_rsp_rdata", rsp_rdata, 8'hA5);
        @(posedge clk); #1;

        // Reset during the second ACCESS cycle of a write.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h20; req_wdata = 8'h77;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check1("mid_access_cs", mem_cs, 1'b1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check1("mid_rst_cs", mem_cs, 1'b0);
        check1("mid_rst_we", mem_we, 1'b0);
        check1("mid_rst_oe", mem_oe, 1'b0);
        check8("mid_rst_addr", mem_address, 8'h00);
        check8("mid_rst_data", mem_data_in, 8'h00);
        check1("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check8("mid_rst_rsp_rdata", rsp_rdata, 8'h00);
        check1("mid_rst_ready", req_ready, 1'b0);
        @(negedge clk); rst = 1'b0;
        #1 check1("mid_rst_release_ready", req_ready, 1'b1);
        repeat (6) begin
            @(posedge clk); #1;
            check1("mid_rst_no_rsp", rsp_valid, 1'b0);
        end

        // Full address sweep, back to back.
        for (int i = 0; i < 256; i++) xact(1'b1, 8'(i), ~8'(i), i > 0);
        for (int i = 0; i < 256; i++) xact(1'b0, 8'(i), 8'h00, 1'b1);

        // Random mix; every location is defined after the sweep.
        for (int i = 0; i < 150; i++)
            xact(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'b1);

        // WAIT_CYCLES=1 instance: three-edge latency.
        xact2(1'b1, 8'h3C, 8'hA5, 8'h00);
        xact2(1'b0, 8'h3C, 8'h00, 8'hA5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
